// File: rtl/pps_timestamp_if.sv
// Event timestamp handshake between pps_timestamp and the readout logic.
// The timestamping block is the slave; the register/readout side is the master.
interface pps_timestamp_if #(
    parameter int SEC_WIDTH    = 32,
    parameter int SUBSEC_WIDTH = 32
);
    logic                    event_i;
    logic                    ts_ack_i;
    logic                    ts_valid_o;
    logic [SEC_WIDTH-1:0]    ts_sec_o;
    logic [SUBSEC_WIDTH-1:0] ts_subsec_o;
    logic                    ts_overflow_o;

    modport master (
        output event_i,
        output ts_ack_i,
        input  ts_valid_o,
        input  ts_sec_o,
        input  ts_subsec_o,
        input  ts_overflow_o
    );

    modport slave (
        input  event_i,
        input  ts_ack_i,
        output ts_valid_o,
        output ts_sec_o,
        output ts_subsec_o,
        output ts_overflow_o
    );
endinterface

// File: rtl/pps_timestamp.sv
// PPS consumer: seconds / sub-second counters, period qualification with a
// lock state machine, and event timestamping with a valid/ack handshake.
//
// state       | meaning
// ------------+------------------------------------------------------------
// UNLOCKED    | no reference flag yet (after reset or a PPS timeout)
// ACQUIRE     | reference seen, counting consecutive good periods
// LOCKED      | LOCK_COUNT consecutive good periods observed
module pps_timestamp #(
    parameter int SUBSEC_WIDTH   = 32,
    parameter int SEC_WIDTH      = 32,
    parameter int NOMINAL_PERIOD = 125000000,
    parameter int TOLERANCE      = 16,
    parameter int LOCK_COUNT     = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    pps_flag_i,
    pps_timestamp_if.slave          ts,
    output logic [SEC_WIDTH-1:0]    sec_count_o,
    output logic [SUBSEC_WIDTH-1:0] period_o,
    output logic                    period_valid_o,
    output logic                    locked_o,
    output logic                    pps_missing_o,
    output logic [7:0]              err_count_o
);
    localparam logic [1:0] ST_UNLOCKED = 2'd0;
    localparam logic [1:0] ST_ACQUIRE  = 2'd1;
    localparam logic [1:0] ST_LOCKED   = 2'd2;

    localparam int W1 = SUBSEC_WIDTH + 1;

    // Bounds are evaluated one bit wider than the counter so a saturated
    // counter plus one cannot wrap into the good window.
    localparam logic [SUBSEC_WIDTH:0] PER_LO =
        (NOMINAL_PERIOD > TOLERANCE) ? W1'(NOMINAL_PERIOD - TOLERANCE) : '0;
    localparam logic [SUBSEC_WIDTH:0] PER_HI =
        W1'(NOMINAL_PERIOD) + W1'(TOLERANCE);
    localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);

    logic [1:0]              state;
    logic [3:0]              good_cnt;
    logic [SUBSEC_WIDTH-1:0] subsec;
    logic [SUBSEC_WIDTH:0]   period_next;
    logic                    period_good;
    logic                    timeout_hit;
    logic                    err_inc;
    logic                    capture;

    assign period_next = {1'b0, subsec} + W1'(1);
    assign period_good = (period_next >= PER_LO) && (period_next <= PER_HI);

    // Timeout fires on the edge where subsec would step to PER_HI+1; a flag on
    // that same edge is simply a (bad) period and takes priority.
    assign timeout_hit = (state != ST_UNLOCKED) && !pps_flag_i &&
                         ({1'b0, subsec} == PER_HI);

    assign err_inc = timeout_hit ||
                     (pps_flag_i && (state != ST_UNLOCKED) && !period_good);

    assign locked_o = (state == ST_LOCKED);

    assign capture = ts.event_i && (!ts.ts_valid_o || ts.ts_ack_i);

    // Free-running sub-second counter (saturating) and seconds counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            subsec      <= '0;
            sec_count_o <= '0;
        end else if (pps_flag_i) begin
            subsec      <= '0;
            sec_count_o <= sec_count_o + SEC_WIDTH'(1);
        end else if (subsec != '1) begin
            subsec      <= subsec + SUBSEC_WIDTH'(1);
        end
    end

    // Lock state machine, period register and PPS-missing pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= ST_UNLOCKED;
            good_cnt       <= '0;
            period_o       <= '0;
            period_valid_o <= 1'b0;
            pps_missing_o  <= 1'b0;
        end else begin
            period_valid_o <= 1'b0;
            pps_missing_o  <= 1'b0;
            if (pps_flag_i) begin
                case (state)
                    ST_UNLOCKED: begin
                        state    <= ST_ACQUIRE;
                        good_cnt <= '0;
                    end
                    ST_ACQUIRE: begin
                        period_o       <= period_next[SUBSEC_WIDTH-1:0];
                        period_valid_o <= 1'b1;
                        if (period_good) begin
                            good_cnt <= good_cnt + 4'd1;
                            if (good_cnt + 4'd1 == LOCK_CNT)
                                state <= ST_LOCKED;
                        end else begin
                            good_cnt <= '0;
                        end
                    end
                    ST_LOCKED: begin
                        period_o       <= period_next[SUBSEC_WIDTH-1:0];
                        period_valid_o <= 1'b1;
                        if (!period_good) begin
                            state    <= ST_ACQUIRE;
                            good_cnt <= '0;
                        end
                    end
                    default: begin
                        state    <= ST_UNLOCKED;
                        good_cnt <= '0;
                    end
                endcase
            end else if (timeout_hit) begin
                pps_missing_o <= 1'b1;
                state         <= ST_UNLOCKED;
                good_cnt      <= '0;
            end
        end
    end

    // Saturating error counter: bad periods plus timeouts.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            err_count_o <= '0;
        else if (err_inc && (err_count_o != 8'hFF))
            err_count_o <= err_count_o + 8'd1;
    end

    // Timestamp capture with single-entry holding register and sticky overflow.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ts.ts_valid_o    <= 1'b0;
            ts.ts_sec_o      <= '0;
            ts.ts_subsec_o   <= '0;
            ts.ts_overflow_o <= 1'b0;
        end else begin
            if (capture) begin
                ts.ts_valid_o  <= 1'b1;
                ts.ts_sec_o    <= sec_count_o;
                ts.ts_subsec_o <= subsec;
            end else if (ts.ts_valid_o && ts.ts_ack_i) begin
                ts.ts_valid_o  <= 1'b0;
            end
            if (ts.event_i && ts.ts_valid_o && !ts.ts_ack_i)
                ts.ts_overflow_o <= 1'b1;
        end
    end
endmodule

// File: tb/tb_pps_timestamp.sv
// Directed bench for pps_timestamp with NOMINAL_PERIOD=1000, TOLERANCE=2,
// LOCK_COUNT=3. Inputs change 1 ns after a rising edge; outputs are read there.
module tb_pps_timestamp;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pps = 1'b0;
    logic [31:0] sec_count;
    logic [31:0] period;
    logic        period_valid;
    logic        locked;
    logic        pps_missing;
    logic [7:0]  err_count;

    int total = 0;
    int bad   = 0;
    int miss_cnt = 0;

    pps_timestamp_if #(.SEC_WIDTH(32), .SUBSEC_WIDTH(32)) ts_bus ();

    pps_timestamp #(
        .SUBSEC_WIDTH(32),
        .SEC_WIDTH(32),
        .NOMINAL_PERIOD(1000),
        .TOLERANCE(2),
        .LOCK_COUNT(3)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .pps_flag_i(pps),
        .ts(ts_bus),
        .sec_count_o(sec_count),
        .period_o(period),
        .period_valid_o(period_valid),
        .locked_o(locked),
        .pps_missing_o(pps_missing),
        .err_count_o(err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (pps_missing === 1'b1) miss_cnt++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic flag_cycle();
        pps = 1'b1;
        step();
        pps = 1'b0;
    endtask

    // Flags n cycles apart: n-1 quiet cycles then the flag.
    task automatic interval(input int n);
        idle(n - 1);
        flag_cycle();
    endtask

    initial begin
        int k;
        int m0;
        bit found;
        ts_bus.event_i  = 1'b0;
        ts_bus.ts_ack_i = 1'b0;

        // Reset state
        idle(2);
        rst = 1'b0;
        chk("rst_sec", sec_count, 0);
        chk("rst_locked", locked, 0);
        chk("rst_err", err_count, 0);
        chk("rst_period", period, 0);
        chk("rst_valid", ts_bus.ts_valid_o, 0);

        // 1: five flags 1000 apart -> lock after flag 4
        flag_cycle();
        chk("t1_f1_pv", period_valid, 0);
        chk("t1_f1_sec", sec_count, 1);
        interval(1000);
        chk("t1_f2_pv", period_valid, 1);
        chk("t1_f2_period", period, 1000);
        step();
        chk("t1_pv_single", period_valid, 0);
        idle(998);
        flag_cycle();
        chk("t1_f3_pv", period_valid, 1);
        chk("t1_f3_locked", locked, 0);
        interval(1000);
        chk("t1_f4_locked", locked, 1);
        interval(1000);
        chk("t1_f5_pv", period_valid, 1);
        chk("t1_sec", sec_count, 5);
        chk("t1_err", err_count, 0);

        // 2: long interval (passes the timeout point) then 998/1002/1000
        interval(1005);
        chk("t2_err", err_count, 1);
        chk("t2_unlocked", locked, 0);
        interval(998);
        chk("t2_998_pv", period_valid, 1);
        chk("t2_998_locked", locked, 0);
        interval(1002);
        chk("t2_1002_period", period, 1002);
        chk("t2_1002_locked", locked, 0);
        interval(1000);
        chk("t2_relock", locked, 1);
        chk("t2_sec", sec_count, 9);
        chk("t2_err2", err_count, 1);

        // 2b: interval 1003 -- flag coincides with the timeout edge, flag wins
        m0 = miss_cnt;
        interval(1003);
        chk("t2b_pv", period_valid, 1);
        chk("t2b_period", period, 1003);
        chk("t2b_err", err_count, 2);
        chk("t2b_locked", locked, 0);
        chk("t2b_no_miss", miss_cnt - m0, 0);
        interval(1000);
        interval(1000);
        interval(1000);
        chk("t2b_relock", locked, 1);
        chk("t2b_sec", sec_count, 13);

        // 3: flags stop -> single pps_missing pulse 1003 cycles later
        k = 0;
        found = 0;
        m0 = miss_cnt;
        while (!found && k < 2000) begin
            step();
            k++;
            if (pps_missing === 1'b1) found = 1;
        end
        chk("t3_found", found, 1);
        chk("t3_delay", k, 1003);
        chk("t3_locked", locked, 0);
        chk("t3_err", err_count, 3);
        idle(5000);
        chk("t3_once", miss_cnt - m0, 1);
        flag_cycle();
        chk("t3_flag_pv", period_valid, 0);
        chk("t3_sec", sec_count, 14);
        chk("t3_err2", err_count, 3);

        // 5: event coincident with the flag moving sec 3 -> 4
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_rst_sec", sec_count, 0);
        flag_cycle();
        interval(1000);
        interval(1000);
        chk("t5_sec3", sec_count, 3);
        idle(999);
        pps = 1'b1;
        ts_bus.event_i = 1'b1;
        step();
        pps = 1'b0;
        ts_bus.event_i = 1'b0;
        chk("t5_valid", ts_bus.ts_valid_o, 1);
        chk("t5_ts_sec", ts_bus.ts_sec_o, 3);
        chk("t5_ts_subsec", ts_bus.ts_subsec_o, 999);
        chk("t5_locked", locked, 1);
        ts_bus.event_i  = 1'b1;
        ts_bus.ts_ack_i = 1'b1;
        step();
        ts_bus.event_i  = 1'b0;
        chk("t5_ea_valid", ts_bus.ts_valid_o, 1);
        chk("t5_ea_sec", ts_bus.ts_sec_o, 4);
        chk("t5_ea_subsec", ts_bus.ts_subsec_o, 0);
        chk("t5_ea_ovf", ts_bus.ts_overflow_o, 0);
        step();
        ts_bus.ts_ack_i = 1'b0;
        chk("t5_ack_valid", ts_bus.ts_valid_o, 0);

        // 4: event 10 cycles after the flag that sets sec to 7
        idle(997);
        flag_cycle();
        interval(1000);
        interval(1000);
        chk("t4_sec7", sec_count, 7);
        idle(9);
        ts_bus.event_i = 1'b1;
        step();
        ts_bus.event_i = 1'b0;
        chk("t4_valid", ts_bus.ts_valid_o, 1);
        chk("t4_ts_sec", ts_bus.ts_sec_o, 7);
        chk("t4_ts_subsec", ts_bus.ts_subsec_o, 9);
        ts_bus.event_i = 1'b1;
        step();
        ts_bus.event_i = 1'b0;
        chk("t4_ovf", ts_bus.ts_overflow_o, 1);
        chk("t4_hold_subsec", ts_bus.ts_subsec_o, 9);
        chk("t4_hold_valid", ts_bus.ts_valid_o, 1);
        ts_bus.ts_ack_i = 1'b1;
        step();
        chk("t4_ack_valid", ts_bus.ts_valid_o, 0);
        step();
        ts_bus.ts_ack_i = 1'b0;
        chk("t4_idle_ack", ts_bus.ts_valid_o, 0);
        chk("t4_ovf_sticky", ts_bus.ts_overflow_o, 1);

        // 6: reset with a held timestamp while locked
        ts_bus.event_i = 1'b1;
        step();
        ts_bus.event_i = 1'b0;
        chk("t6_pre_valid", ts_bus.ts_valid_o, 1);
        chk("t6_pre_locked", locked, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_valid", ts_bus.ts_valid_o, 0);
        chk("t6_ovf", ts_bus.ts_overflow_o, 0);
        chk("t6_ts_sec", ts_bus.ts_sec_o, 0);
        chk("t6_ts_subsec", ts_bus.ts_subsec_o, 0);
        chk("t6_sec", sec_count, 0);
        chk("t6_locked", locked, 0);
        chk("t6_period", period, 0);
        chk("t6_err", err_count, 0);
        flag_cycle();
        chk("t6_flag_pv", period_valid, 0);
        chk("t6_flag_sec", sec_count, 1);
        interval(1000);
        chk("t6_acq_pv", period_valid, 1);
        chk("t6_acq_period", period, 1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pps_timestamp.md
Name: pps_timestamp

Overview:
Downstream consumer of the single-cycle PPS flag produced by the PPS core, in the same ext clock domain.
- Maintains a seconds counter and a sub-second clock counter.
- Measures the clock-cycle period between PPS flags and qualifies it against a nominal value, running a lock state machine.
- Timestamps asynchronous-to-PPS event strobes with a valid/ack handshake for the register/readout logic.

Parameters:
SUBSEC_WIDTH, 32, width of sub-second counter and period register.
SEC_WIDTH, 32, width of seconds counter.
NOMINAL_PERIOD, 125000000, expected clocks between PPS flags.
TOLERANCE, 16, allowed |period - NOMINAL_PERIOD| for a good period.
LOCK_COUNT, 3, consecutive good periods needed to enter LOCKED (1..15).

Ports:
clk_i  in  1  ext clock (same clock as the PPS flag).
rst_i  in  1  synchronous active-high reset.
pps_flag_i  in  1  single-cycle PPS flag from the PPS core.
event_i  in  1  event strobe; sampled every cycle while high.
ts_ack_i  in  1  consumer acknowledges the held timestamp.
ts_valid_o  out  1  timestamp held and valid.
ts_sec_o  out  SEC_WIDTH  captured seconds.
ts_subsec_o  out  SUBSEC_WIDTH  captured sub-second count.
ts_overflow_o  out  1  sticky: an event was dropped.
sec_count_o  out  SEC_WIDTH  live seconds counter.
period_o  out  SUBSEC_WIDTH  last measured period.
period_valid_o  out  1  one-cycle pulse when period_o is updated and evaluated.
locked_o  out  1  FSM in LOCKED.
pps_missing_o  out  1  one-cycle pulse on PPS timeout.
err_count_o  out  8  bad-period plus timeout count, saturates at 255.

Behaviour:
Reset:
- All outputs, counters and registers go to 0; FSM goes to UNLOCKED.
- Reset mid-handshake discards the held timestamp.

Sub-second counter (subsec):
- On a cycle with pps_flag_i=1: subsec<=0.
- Otherwise: subsec<=subsec+1, saturating at all-ones (no wrap).
- For flags N cycles apart, subsec equals N-1 on the second flag cycle.

Seconds counter:
- sec_count_o increments on every pps_flag_i, in every state.
- Wraps modulo 2^SEC_WIDTH.

Period measurement:
- On a flag in ACQUIRE or LOCKED: period_o<=subsec+1 and period_valid_o pulses on the next cycle.
- Good period: NOMINAL_PERIOD-TOLERANCE <= period <= NOMINAL_PERIOD+TOLERANCE. Compare at SUBSEC_WIDTH+1 bits; no underflow.
- On a flag in UNLOCKED: period_o is unchanged and no pulse is produced.

FSM (UNLOCKED, ACQUIRE, LOCKED; good_cnt is 4 bits):
- UNLOCKED + flag -> ACQUIRE, good_cnt=0. This first flag is only the reference.
- ACQUIRE + flag with good period -> good_cnt+1. When the new value equals LOCK_COUNT -> LOCKED.
- ACQUIRE + flag with bad period -> good_cnt=0, err+1, stay in ACQUIRE.
- LOCKED + flag with bad period -> ACQUIRE, good_cnt=0, err+1.
- Timeout:
  - Condition: FSM not UNLOCKED and subsec reaches NOMINAL_PERIOD+TOLERANCE+1 without a flag.
  - Effect: pps_missing_o pulses once, err+1, FSM -> UNLOCKED.
  - The pulse is not repeated until a flag is seen.
  - No synthetic seconds are inserted.
- Flag and timeout in the same cycle: the flag wins and no timeout is raised.
- err_count_o saturates at 255. Two increments are never needed in one cycle.

Event timestamp handshake:
- Captured values are the counter values of the event cycle, before that cycle's updates. An event coincident with a flag captures the old sec and subsec=N-1.
- event_i=1 and ts_valid_o=0: capture; ts_valid_o=1 on the next cycle.
- ts_valid_o=1 and ts_ack_i=1 without an event: ts_valid_o<=0 on the next cycle.
- ts_valid_o=1, ts_ack_i=1 and event_i=1: new capture, ts_valid_o stays 1.
- ts_valid_o=1, ts_ack_i=0 and event_i=1: event dropped, held data unchanged, ts_overflow_o<=1.
- ts_overflow_o clears only on reset.
- ts_ack_i while ts_valid_o=0: ignored.
- A multi-cycle event_i high produces a capture on each eligible cycle, per the rules above.

Test Plan:
(Bench uses NOMINAL_PERIOD=1000, TOLERANCE=2, LOCK_COUNT=3.)
1. Flags every 1000 cycles, 5 flags -> period_valid_o pulses on flags 2-5; period_o=1000; locked_o rises one cycle after flag 4; sec_count_o=5; err_count_o=0.
2. While locked, one interval of 1005 cycles -> err_count_o=1, locked_o drops; three further good intervals (998, 1002, 1000) -> locked_o=1 again.
3. While locked, flags stop -> pps_missing_o pulses once, 1003 cycles after the last flag; locked_o=0; err_count_o+1; no further pulses over 5000 cycles. Next flag -> ACQUIRE, no period_valid_o pulse.
4. event_i pulse 10 cycles after the flag that set sec_count_o to 7 -> ts_sec_o=7, ts_subsec_o=9, ts_valid_o=1. Second event before ack -> ts_overflow_o=1 and data unchanged. Ack -> ts_valid_o=0.
5. event_i coincident with the flag that moves sec_count_o from 3 to 4, interval 1000 -> ts_sec_o=3, ts_subsec_o=999. Event and ack in the same cycle -> ts_valid_o stays 1 with the new data.
6. rst_i asserted with ts_valid_o=1 in LOCKED -> next cycle all outputs 0, FSM UNLOCKED; the next flag gives no period_valid_o pulse.
